// File: rtl/detector_event_sequencer.sv
// Detector event sequencer: arms on cfg_run, opens a coincidence window on the
// first masked hit, ORs all masked hits seen during the window into one event
// word, emits it on an AXI-Stream master, then holds off for a dead time.
// Optional build macro DETECTOR_EVENT_SEQUENCER_TIMESTAMP_EN adds a 32-bit
// free-running timestamp captured at the trigger and sent as a second beat.
module detector_event_sequencer #(
  parameter int WINDOW_WIDTH = 8,
  parameter int DEAD_WIDTH   = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [63:0]             det_data,
  input  logic                    cfg_run,
  input  logic [63:0]             cfg_mask,
  input  logic [WINDOW_WIDTH-1:0] cfg_window,
  input  logic [DEAD_WIDTH-1:0]   cfg_dead,
  output logic [63:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [31:0]             sts_events,
  output logic [31:0]             sts_dropped,
  output logic                    sts_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_WINDOW = 3'd2,
    S_EMIT   = 3'd3,
    S_DEAD   = 3'd4
  } state_t;

  // A programmed window of zero still means one cycle: the trigger cycle.
  function automatic logic [WINDOW_WIDTH-1:0] window_len(input logic [WINDOW_WIDTH-1:0] w);
    return (w == '0) ? WINDOW_WIDTH'(1) : w;
  endfunction

  // Saturating 32-bit increment for the drop counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t                  state;
  state_t                  state_nxt;
  logic [63:0]             masked;
  logic                    hit;
  logic [63:0]             acc;
  logic [WINDOW_WIDTH-1:0] win_len;
  logic [WINDOW_WIDTH-1:0] win_cnt;
  logic [DEAD_WIDTH-1:0]   dead_cnt;
  logic                    trigger;
  logic                    win_done;
  logic                    dead_done;
  logic                    hs;
  logic                    last_hs;
  logic                    last_beat;
  logic [63:0]             beat_word;

  assign masked    = det_data & cfg_mask;
  assign hit       = |masked;
  assign trigger   = (state == S_ARMED) && cfg_run && hit;
  assign win_done  = (state == S_WINDOW) && ((win_cnt + WINDOW_WIDTH'(1)) == win_len);
  assign dead_done = (state == S_DEAD) && (dead_cnt == DEAD_WIDTH'(1));
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign last_hs   = hs && m_axis_tlast;

`ifdef DETECTOR_EVENT_SEQUENCER_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_cap;
  logic        beat;

  // Free-running timestamp; the value seen on the trigger cycle is kept for beat1
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_cnt <= 32'd0;
      ts_cap <= 32'd0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trigger) ts_cap <= ts_cnt;
    end
  end

  // Beat index within the two-beat event; returns to 0 after the final beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) beat <= 1'b0;
    else if (hs)  beat <= ~beat;
  end

  assign last_beat = beat;
  assign beat_word = beat ? {32'd0, ts_cap} : acc;
`else
  assign last_beat = 1'b1;
  assign beat_word = acc;
`endif

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; cfg_run only matters when leaving IDLE/ARMED or at sequence exit
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cfg_run) state_nxt = S_ARMED;
      S_ARMED: begin
        if (!cfg_run)                                     state_nxt = S_IDLE;
        else if (hit && window_len(cfg_window) == WINDOW_WIDTH'(1)) state_nxt = S_EMIT;
        else if (hit)                                     state_nxt = S_WINDOW;
      end
      S_WINDOW: if (win_done) state_nxt = S_EMIT;
      S_EMIT: begin
        if (last_hs) begin
          if (cfg_dead != '0) state_nxt = S_DEAD;
          else                state_nxt = cfg_run ? S_ARMED : S_IDLE;
        end
      end
      S_DEAD:   if (dead_done) state_nxt = cfg_run ? S_ARMED : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; event word is held in acc/ts_cap so it is stable until accepted
  always_comb begin
    m_axis_tvalid = (state == S_EMIT);
    m_axis_tlast  = m_axis_tvalid && last_beat;
    m_axis_tdata  = m_axis_tvalid ? beat_word : 64'd0;
    sts_busy      = (state == S_WINDOW) || (state == S_EMIT) || (state == S_DEAD);
  end

  // Window accumulator and window/dead counters, latched at trigger and final handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc      <= 64'd0;
      win_len  <= '0;
      win_cnt  <= '0;
      dead_cnt <= '0;
    end else begin
      if (trigger) begin
        acc     <= masked;
        win_len <= window_len(cfg_window);
        win_cnt <= WINDOW_WIDTH'(1);
      end else if (state == S_WINDOW) begin
        acc     <= acc | masked;
        win_cnt <= win_cnt + WINDOW_WIDTH'(1);
      end
      if (last_hs)               dead_cnt <= cfg_dead;
      else if (state == S_DEAD)  dead_cnt <= dead_cnt - DEAD_WIDTH'(1);
    end
  end

  // Status counters: events wrap, dropped hit-cycles saturate
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sts_events  <= 32'd0;
      sts_dropped <= 32'd0;
    end else begin
      if (last_hs) sts_events <= sts_events + 32'd1;
      if (hit && (state == S_EMIT || state == S_DEAD)) sts_dropped <= sat_inc32(sts_dropped);
    end
  end

endmodule

// File: tb/tb_detector_event_sequencer.sv
// Bench for detector_event_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference.
module tb_detector_event_sequencer;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] LO32 = 64'h0000_0000_FFFF_FFFF;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] det_data = 64'd0;
  logic        cfg_run = 1'b0;
  logic [63:0] cfg_mask = 64'd0;
  logic [7:0]  cfg_window = 8'd0;
  logic [15:0] cfg_dead = 16'd0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [31:0] sts_events;
  logic [31:0] sts_dropped;
  logic        sts_busy;

  always #5 aclk = ~aclk;

  detector_event_sequencer #(.WINDOW_WIDTH(8), .DEAD_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .det_data(det_data), .cfg_run(cfg_run),
    .cfg_mask(cfg_mask), .cfg_window(cfg_window), .cfg_dead(cfg_dead),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .sts_events(sts_events), .sts_dropped(sts_dropped), .sts_busy(sts_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an event is a list of beats waiting to be accepted; the phase of
  // the sequence is implied by which of window/beats/dead is outstanding.
  logic        m_armed;
  int          m_win_left;
  int          m_dead_left;
  logic [63:0] m_acc;
  logic [31:0] m_ts;
  logic [31:0] m_ts_cap;
  logic [63:0] m_beats[$];
  logic [31:0] m_events;
  logic [31:0] m_dropped;

  function automatic void model_reset();
    m_armed = 1'b0; m_win_left = 0; m_dead_left = 0; m_acc = 64'd0;
    m_ts = 32'd0; m_ts_cap = 32'd0; m_beats.delete();
    m_events = 32'd0; m_dropped = 32'd0;
  endfunction

  function automatic void push_event();
    m_beats.push_back(m_acc);
`ifdef DETECTOR_EVENT_SEQUENCER_TIMESTAMP_EN
    m_beats.push_back({32'd0, m_ts_cap});
`endif
  endfunction

  function automatic void count_drop();
    if (m_dropped != 32'hFFFF_FFFF) m_dropped = m_dropped + 32'd1;
  endfunction

  function automatic void model_step();
    logic [63:0] mk;
    logic        h;
    mk = det_data & cfg_mask;
    h  = |mk;
    if (m_beats.size() > 0) begin
      if (h) count_drop();
      if (m_axis_tready) begin
        void'(m_beats.pop_front());
        if (m_beats.size() == 0) begin
          m_events = m_events + 32'd1;
          if (cfg_dead == 16'd0) m_armed = cfg_run;
          else m_dead_left = int'(cfg_dead);
        end
      end
    end else if (m_dead_left > 0) begin
      if (h) count_drop();
      m_dead_left--;
      if (m_dead_left == 0) m_armed = cfg_run;
    end else if (m_win_left > 0) begin
      m_acc = m_acc | mk;
      m_win_left--;
      if (m_win_left == 0) push_event();
    end else if (m_armed) begin
      if (!cfg_run) m_armed = 1'b0;
      else if (h) begin
        m_armed    = 1'b0;
        m_acc      = mk;
        m_ts_cap   = m_ts;
        m_win_left = ((cfg_window == 8'd0) ? 1 : int'(cfg_window)) - 1;
        if (m_win_left == 0) push_event();
      end
    end else if (cfg_run) begin
      m_armed = 1'b1;
    end
    m_ts = m_ts + 32'd1;
  endfunction

  task automatic check_model();
    logic e_valid;
    logic e_busy;
    e_valid = (m_beats.size() > 0);
    e_busy  = (m_win_left > 0) || (m_beats.size() > 0) || (m_dead_left > 0);
    chk("tvalid", 64'(m_axis_tvalid), 64'(e_valid));
    if (e_valid) begin
      chk("tdata", m_axis_tdata, m_beats[0]);
      chk("tlast", 64'(m_axis_tlast), 64'(m_beats.size() == 1));
    end
    chk("busy", 64'(sts_busy), 64'(e_busy));
    chk("events", 64'(sts_events), 64'(m_events));
    chk("dropped", 64'(sts_dropped), 64'(m_dropped));
  endtask

  // Inputs change #1 after a rising edge; outputs are checked on the falling edge.
  task automatic tick_pre();
    @(negedge aclk);
    check_model();
  endtask

  task automatic tick_post();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_busy", 64'(sts_busy), 64'd0);
    chk("rst_events", 64'(sts_events), 64'd0);
    chk("rst_dropped", 64'(sts_dropped), 64'd0);
    model_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  typedef struct {
    logic        run;
    logic [63:0] det;
    logic [63:0] mask;
    logic [7:0]  win;
    logic        e_valid;
    logic [63:0] e_data;
    logic        e_last;
    logic        e_busy;
    logic [31:0] e_events;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mv(logic run, logic [63:0] det, logic [63:0] mask, logic [7:0] win,
                              logic ev, logic [63:0] ed, logic el, logic eb, logic [31:0] ec);
    vec_t v;
    v.run = run; v.det = det; v.mask = mask; v.win = win;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_busy = eb; v.e_events = ec;
    return v;
  endfunction

  initial begin
    bit found;
    int n;

    // Window of 4 with late hit, then a zero window, then a masked-off hit.
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd4, 0, 64'd0, 0, 0, 0));
    tbl.push_back(mv(1, 64'd1 << 3,   ALL1, 8'd4, 0, 64'd0, 0, 0, 0));
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd4, 0, 64'd0, 0, 1, 0));
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd4, 0, 64'd0, 0, 1, 0));
    tbl.push_back(mv(1, 64'd1 << 40,  ALL1, 8'd4, 0, 64'd0, 0, 1, 0));
`ifdef DETECTOR_EVENT_SEQUENCER_TIMESTAMP_EN
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd4, 1, 64'h0000_0100_0000_0008, 0, 1, 0));
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd0, 1, 64'd1, 1, 1, 0));
    tbl.push_back(mv(1, 64'd1,        ALL1, 8'd0, 0, 64'd0, 0, 0, 1));
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd0, 1, 64'd1, 0, 1, 1));
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd0, 1, 64'd7, 1, 1, 1));
`else
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd4, 1, 64'h0000_0100_0000_0008, 1, 1, 0));
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd0, 0, 64'd0, 0, 0, 1));
    tbl.push_back(mv(1, 64'd1,        ALL1, 8'd0, 0, 64'd0, 0, 0, 1));
    tbl.push_back(mv(1, 64'd0,        ALL1, 8'd0, 1, 64'd1, 1, 1, 1));
`endif
    tbl.push_back(mv(1, 64'd1 << 63,  LO32, 8'd0, 0, 64'd0, 0, 0, 2));
    tbl.push_back(mv(1, 64'd1 << 63,  LO32, 8'd0, 0, 64'd0, 0, 0, 2));
    tbl.push_back(mv(1, 64'd1 << 63,  LO32, 8'd0, 0, 64'd0, 0, 0, 2));

    do_reset();
    m_axis_tready = 1'b1;
    cfg_dead = 16'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      cfg_run = tbl[i].run; det_data = tbl[i].det; cfg_mask = tbl[i].mask; cfg_window = tbl[i].win;
      tick_pre();
      chk($sformatf("vec%0d_tvalid", i), 64'(m_axis_tvalid), 64'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_tdata", i), m_axis_tdata, tbl[i].e_data);
        chk($sformatf("vec%0d_tlast", i), 64'(m_axis_tlast), 64'(tbl[i].e_last));
      end
      chk($sformatf("vec%0d_busy", i), 64'(sts_busy), 64'(tbl[i].e_busy));
      chk($sformatf("vec%0d_events", i), 64'(sts_events), 64'(tbl[i].e_events));
      tick_post();
    end

    // Backpressure with a held hit, then a 5-cycle dead time.
    cfg_mask = ALL1; cfg_window = 8'd2; cfg_dead = 16'd5; m_axis_tready = 1'b0;
    det_data = 64'd1 << 5;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick_pre();
      if (m_axis_tvalid) found = 1'b1;
      else tick_post();
    end
    chk("bp_wait_tvalid", 64'(found), 64'd1);
    tick_post();
    for (int i = 0; i < 9; i++) tick();
    det_data = 64'd0; m_axis_tready = 1'b1;
    tick_pre();
    chk("bp_tdata_held", m_axis_tdata, 64'h20);
    chk("bp_dropped", 64'(sts_dropped), 64'd10);
    tick_post();
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick_pre();
      if (!m_axis_tvalid) found = 1'b1;
      else tick_post();
    end
    chk("bp_wait_accept", 64'(found), 64'd1);
    n = 0;
    while (sts_busy && n < 20) begin
      n++;
      tick_post();
      tick_pre();
    end
    chk("dead_cycles", 64'(n), 64'd5);
    chk("dead_events", 64'(sts_events), 64'd3);
    tick_post();

    // cfg_run dropped inside an 8-cycle window: event completes, then IDLE.
    cfg_window = 8'd8; cfg_dead = 16'd0;
    det_data = 64'd1 << 9;
    tick();
    det_data = 64'd0; cfg_run = 1'b0;
    tick();
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick_pre();
      if (m_axis_tvalid) found = 1'b1;
      else tick_post();
    end
    chk("run0_wait_tvalid", 64'(found), 64'd1);
    chk("run0_tdata", m_axis_tdata, 64'd1 << 9);
    tick_post();
    for (int i = 0; i < 3; i++) tick();
    det_data = 64'd1 << 2;
    for (int i = 0; i < 3; i++) tick();
    tick_pre();
    chk("run0_idle_busy", 64'(sts_busy), 64'd0);
    chk("run0_events", 64'(sts_events), 64'd4);
    tick_post();

    // Reset in the middle of an event that is being back-pressured.
    cfg_run = 1'b1; det_data = 64'd0; m_axis_tready = 1'b0; cfg_window = 8'd2;
    tick();
    det_data = 64'd1 << 2;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick_pre();
      if (m_axis_tvalid) found = 1'b1;
      else tick_post();
    end
    chk("rst_mid_wait_tvalid", 64'(found), 64'd1);
    det_data = 64'd0;
    do_reset();

`ifdef DETECTOR_EVENT_SEQUENCER_TIMESTAMP_EN
    // Trigger exactly when the timestamp reads 0x123.
    cfg_run = 1'b1; cfg_mask = ALL1; cfg_window = 8'd1; cfg_dead = 16'd0;
    m_axis_tready = 1'b1; det_data = 64'd0;
    n = 0;
    while (m_ts != 32'h123 && n < 1000) begin
      tick();
      n++;
    end
    chk("ts_reach", 64'(m_ts), 64'h123);
    det_data = 64'd1 << 1;
    tick();
    det_data = 64'd0;
    tick_pre();
    chk("ts_beat0_tdata", m_axis_tdata, 64'd2);
    chk("ts_beat0_tlast", 64'(m_axis_tlast), 64'd0);
    tick_post();
    tick_pre();
    chk("ts_beat1_tdata", m_axis_tdata, 64'h0000_0000_0000_0123);
    chk("ts_beat1_tlast", 64'(m_axis_tlast), 64'd1);
    tick_post();
    do_reset();
`endif

    // Randomized traffic against the reference.
    cfg_run = 1'b1; cfg_mask = ALL1;
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 7))
        0:       det_data = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        1, 2:    det_data = 64'd1 << $urandom_range(0, 63);
        default: det_data = 64'd0;
      endcase
      if (c % 250 == 0) cfg_mask = ($urandom_range(0, 1) == 0) ? ALL1 : {$urandom, $urandom};
      if ($urandom_range(0, 59) == 0) cfg_run = ~cfg_run;
      cfg_window    = 8'($urandom_range(0, 7));
      cfg_dead      = 16'($urandom_range(0, 4));
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/detector_event_sequencer.md
DETECTOR_EVENT_SEQUENCER -- requirements
Module: detector_event_sequencer

Interface
REQ-001 SHALL have parameter WINDOW_WIDTH, default 8, meaning the width of cfg_window.
REQ-002 SHALL have parameter DEAD_WIDTH, default 16, meaning the width of cfg_dead.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; no other clock domain.
REQ-004 aclk  in  1  sole clock.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 det_data  in  64  detector hit lines, already synchronous to aclk.
REQ-007 cfg_run  in  1  run enable.
REQ-008 cfg_mask  in  64  channel enable mask.
REQ-009 cfg_window  in  WINDOW_WIDTH  coincidence window length in cycles.
REQ-010 cfg_dead  in  DEAD_WIDTH  dead time in cycles after emission.
REQ-011 m_axis_tdata  out  64  event word.
REQ-012 m_axis_tvalid  out  1  AXI-Stream valid.
REQ-013 m_axis_tready  in  1  AXI-Stream ready.
REQ-014 m_axis_tlast  out  1  last beat of event.
REQ-015 sts_events  out  32  emitted event count.
REQ-016 sts_dropped  out  32  dropped hit-cycle count.
REQ-017 sts_busy  out  1  high in WINDOW, EMIT or DEAD.

Function
REQ-018 SHALL define masked = det_data & cfg_mask; hit = |masked.
REQ-019 SHALL implement FSM states IDLE, ARMED, WINDOW, EMIT and DEAD.
REQ-020 IDLE: SHALL go to ARMED on the cycle after cfg_run=1.
REQ-021 ARMED: on cfg_run=0, SHALL go to IDLE; else on hit, SHALL go to WINDOW, load acc<=masked, latch len=max(cfg_window,1) and set cnt=1.
REQ-022 WINDOW: SHALL do acc<=acc|masked each cycle; window = len cycles including the trigger cycle; SHALL enter EMIT after the last window cycle.
REQ-023 When len=1, SHALL enter EMIT on the cycle after the trigger.
REQ-024 EMIT: SHALL assert tvalid the cycle EMIT is entered, with tdata=acc; tdata/tlast SHALL be stable until tready.
REQ-025 On handshake: if the latched cfg_dead=0, SHALL go to ARMED (cfg_run=1) or IDLE (cfg_run=0); else SHALL go to DEAD.
REQ-026 DEAD: SHALL last exactly cfg_dead cycles (latched at handshake), then go to ARMED or IDLE per cfg_run.
REQ-027 cfg_run=0 during WINDOW/EMIT/DEAD SHALL NOT truncate the sequence; it takes effect at exit.
REQ-028 Hits in EMIT or DEAD SHALL be ignored; sts_dropped SHALL increment once per such cycle with hit=1 and saturate at 0xFFFFFFFF.
REQ-029 sts_events SHALL increment on the tlast handshake and wrap 0xFFFFFFFF->0.
REQ-030 tlast SHALL equal 1 on the final beat of each event only.
REQ-031 cfg_mask changes SHALL affect masked on the same cycle; cfg_window/cfg_dead SHALL take effect only at their latch points.

Reset
REQ-032 aresetn=0 SHALL immediately force state=IDLE; tvalid, tlast, tdata, acc, counters, sts_events, sts_dropped and sts_busy SHALL be 0.
REQ-033 Reset mid-EMIT SHALL drop tvalid asynchronously and discard the pending event.
REQ-034 After release, the first state change SHALL occur on a rising edge of aclk, with cfg_run sampled.

Configuration
REQ-035 Macro DETECTOR_EVENT_SEQUENCER_TIMESTAMP_EN SHALL be used.
REQ-036 With the macro defined: SHALL keep a 32-bit free-running counter (0 at reset, wraps) and capture it on the trigger cycle; events SHALL be two beats: beat0 tdata=acc, tlast=0; beat1 tdata={32'd0,ts}, tlast=1.
REQ-037 Without the macro: SHALL emit one beat (tdata=acc, tlast=1) with no timestamp logic.

Verification
REQ-038 cfg_window=4, cfg_mask=all ones, bit3 pulse at t0, bit40 at t0+3, tready=1 -> tvalid at t0+4, tdata=0x0000010000000008, sts_events=1.
REQ-039 cfg_window=0, single-cycle hit on bit0 -> one-cycle window, tdata=0x1.
REQ-040 tready=0 for 10 cycles with hit held -> tdata stable, sts_dropped=10, then cfg_dead=5 -> ARMED exactly 5 cycles after the handshake.
REQ-041 cfg_mask=0x00000000FFFFFFFF, hit on bit63 only -> no trigger, state remains ARMED, sts_events=0.
REQ-042 cfg_run=0 at WINDOW cycle 2 of 8 -> full event emitted, then IDLE; aresetn=0 mid-EMIT -> tvalid=0 immediately, counters=0.
REQ-043 TIMESTAMP_EN build, trigger when timestamp=0x00000123 -> beat1 tdata=0x0000000000000123, tlast only on beat1.
